// File: rtl/envelope_bank.sv
// envelope_bank: time-multiplexed ADSR envelope generator for N_VOICES.
// Optional macro ENV_EXP_RELEASE_EN: release step grows with level.
module envelope_bank #(
  parameter  int N_VOICES = 8,
  parameter  int LVL_W    = 16,
  parameter  int FRAC_W   = 16,
  localparam int ACC_W    = LVL_W + FRAC_W,
  localparam int VW       = $clog2(N_VOICES)
) (
  input  logic                Sys_clk,
  input  logic                Env_rst_n,
  input  logic                Env_ce,
  input  logic                Syn_tick,
  input  logic [N_VOICES-1:0] Syn_key,
  input  logic [ACC_W-1:0]    A_rate,
  input  logic [ACC_W-1:0]    D_rate,
  input  logic [ACC_W-1:0]    R_rate,
  input  logic [LVL_W-1:0]    S_lvl,
  output logic [LVL_W-1:0]    Env_lvl,
  output logic [VW-1:0]       Env_voice,
  output logic                Env_valid,
  output logic                Env_busy,
  output logic [N_VOICES-1:0] Env_active,
  output logic                Env_ovr
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ATK  = 3'd1,
    ST_DEC  = 3'd2,
    ST_SUS  = 3'd3,
    ST_REL  = 3'd4
  } st_e;

  localparam logic [ACC_W-1:0] PEAK = '1;
  localparam logic [VW-1:0]    LAST = VW'(N_VOICES - 1);

  logic [2:0]       r_st  [N_VOICES];
  logic [ACC_W-1:0] r_acc [N_VOICES];

  logic             r_busy;
  logic [VW-1:0]    r_idx;
  logic             r_pv;
  logic [VW-1:0]    r_pidx;
  logic [LVL_W-1:0] r_plvl;
  logic             r_valid;
  logic [VW-1:0]    r_voice;
  logic [LVL_W-1:0] r_lvl;
  logic             r_ovr;

  logic [2:0]       w_st;
  logic [2:0]       w_nst;
  logic [ACC_W-1:0] w_acc;
  logic [ACC_W-1:0] w_nacc;
  logic             w_key;
  logic [ACC_W-1:0] w_sus;
  logic [ACC_W-1:0] w_abase;
  logic [ACC_W:0]   w_sum;
  logic             w_apk;
  logic [ACC_W:0]   w_dlim;
  logic             w_dsus;
  logic [ACC_W-1:0] w_ddiff;
  logic [ACC_W-1:0] w_rbase;
  logic [ACC_W:0]   w_rdec;
  logic             w_rzero;
  logic [ACC_W-1:0] w_rdiff;
  logic [N_VOICES-1:0] w_active;

  assign w_st    = r_st[r_idx];
  assign w_acc   = r_acc[r_idx];
  assign w_key   = Syn_key[r_idx];
  assign w_sus   = {S_lvl, {FRAC_W{1'b0}}};

  assign w_abase = (w_st == ST_IDLE) ? '0 : w_acc;
  assign w_sum   = {1'b0, w_abase} + {1'b0, A_rate};
  assign w_apk   = w_sum[ACC_W] | (&w_sum[ACC_W-1:0]);

  assign w_dlim  = {1'b0, D_rate} + {1'b0, w_sus};
  assign w_dsus  = ({1'b0, w_acc} <= w_dlim);
  assign w_ddiff = w_acc - D_rate;

  assign w_rbase = (w_st == ST_SUS) ? w_sus : w_acc;
`ifdef ENV_EXP_RELEASE_EN
  assign w_rdec  = {1'b0, R_rate} + {5'b0, w_rbase[ACC_W-1:4]};
`else
  assign w_rdec  = {1'b0, R_rate};
`endif
  assign w_rzero = (w_rdec >= {1'b0, w_rbase});
  assign w_rdiff = w_rbase - w_rdec[ACC_W-1:0];

  // Next state and level of the voice serviced this cycle
  always_comb begin
    w_nst  = ST_IDLE;
    w_nacc = '0;
    case (st_e'(w_st))
      ST_IDLE: begin
        if (w_key) begin
          w_nst  = w_apk ? ST_DEC : ST_ATK;
          w_nacc = w_apk ? PEAK : w_sum[ACC_W-1:0];
        end
      end
      ST_ATK: begin
        if (!w_key) begin
          w_nst  = ST_REL;
          w_nacc = w_acc;
        end else begin
          w_nst  = w_apk ? ST_DEC : ST_ATK;
          w_nacc = w_apk ? PEAK : w_sum[ACC_W-1:0];
        end
      end
      ST_DEC: begin
        if (!w_key) begin
          w_nst  = w_rzero ? ST_IDLE : ST_REL;
          w_nacc = w_rzero ? '0 : w_rdiff;
        end else begin
          w_nst  = w_dsus ? ST_SUS : ST_DEC;
          w_nacc = w_dsus ? w_sus : w_ddiff;
        end
      end
      ST_SUS: begin
        if (!w_key) begin
          w_nst  = w_rzero ? ST_IDLE : ST_REL;
          w_nacc = w_rzero ? '0 : w_rdiff;
        end else begin
          w_nst  = ST_SUS;
          w_nacc = w_sus;
        end
      end
      ST_REL: begin
        if (w_key) begin
          w_nst  = w_apk ? ST_DEC : ST_ATK;
          w_nacc = w_apk ? PEAK : w_sum[ACC_W-1:0];
        end else begin
          w_nst  = w_rzero ? ST_IDLE : ST_REL;
          w_nacc = w_rzero ? '0 : w_rdiff;
        end
      end
      default: begin
        w_nst  = ST_IDLE;
        w_nacc = '0;
      end
    endcase
  end

  // Per-voice state and accumulator, written in the voice's service slot
  always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
    if (!Env_rst_n) begin
      for (int v = 0; v < N_VOICES; v++) begin
        r_st[v]  <= ST_IDLE;
        r_acc[v] <= '0;
      end
    end else if (Env_ce && r_busy) begin
      r_st[r_idx]  <= w_nst;
      r_acc[r_idx] <= w_nacc;
    end
  end

  // Sweep sequencer and one-stage result pipeline
  always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
    if (!Env_rst_n) begin
      r_busy <= 1'b0;
      r_idx  <= '0;
      r_pv   <= 1'b0;
      r_pidx <= '0;
      r_plvl <= '0;
    end else if (Env_ce) begin
      r_pv <= r_busy;
      if (r_busy) begin
        r_pidx <= r_idx;
        r_plvl <= w_nacc[ACC_W-1:FRAC_W];
        if (r_idx == LAST) begin
          r_busy <= 1'b0;
          r_idx  <= '0;
        end else begin
          r_idx <= r_idx + VW'(1);
        end
      end else if (Syn_tick) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
      end
    end
  end

  // Registered output stream and overrun pulse
  always_ff @(posedge Sys_clk or negedge Env_rst_n) begin
    if (!Env_rst_n) begin
      r_valid <= 1'b0;
      r_voice <= '0;
      r_lvl   <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= Env_ce & Syn_tick & r_busy;
      if (!Env_ce) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_pv;
        if (r_pv) begin
          r_voice <= r_pidx;
          r_lvl   <= r_plvl;
        end
      end
    end
  end

  // Activity flags straight from the state registers
  always_comb begin
    w_active = '0;
    for (int v = 0; v < N_VOICES; v++) begin
      w_active[v] = (r_st[v] != ST_IDLE);
    end
  end

  assign Env_lvl    = r_lvl;
  assign Env_voice  = r_voice;
  assign Env_valid  = r_valid;
  assign Env_busy   = r_busy;
  assign Env_active = w_active;
  assign Env_ovr    = r_ovr;

endmodule

// File: tb/tb_envelope_bank.sv
// tb_envelope_bank: vector table plus scoreboard for envelope_bank.
// Hand sequences cover overrun, enable pause and mid-sweep reset.
module tb_envelope_bank;

  localparam int NV = 4;
  localparam int LW = 16;
  localparam int FW = 16;
  localparam int AW = LW + FW;

  logic          Sys_clk = 1'b0;
  logic          Env_rst_n = 1'b0;
  logic          Env_ce = 1'b0;
  logic          Syn_tick = 1'b0;
  logic [NV-1:0] Syn_key = '0;
  logic [AW-1:0] A_rate;
  logic [AW-1:0] D_rate;
  logic [AW-1:0] R_rate;
  logic [LW-1:0] S_lvl;
  logic [LW-1:0] Env_lvl;
  logic [1:0]    Env_voice;
  logic          Env_valid;
  logic          Env_busy;
  logic [NV-1:0] Env_active;
  logic          Env_ovr;

  typedef struct packed {
    logic [1:0]  v;
    logic [15:0] l;
  } exp_t;

  typedef struct packed {
    logic [3:0]  key;
    logic [15:0] s;
    logic [63:0] lv;
    logic [3:0]  act;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int   vcyc[$];
  exp_t m_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;

  envelope_bank #(
    .N_VOICES(NV),
    .LVL_W(LW),
    .FRAC_W(FW)
  ) dut (
    .Sys_clk(Sys_clk),
    .Env_rst_n(Env_rst_n),
    .Env_ce(Env_ce),
    .Syn_tick(Syn_tick),
    .Syn_key(Syn_key),
    .A_rate(A_rate),
    .D_rate(D_rate),
    .R_rate(R_rate),
    .S_lvl(S_lvl),
    .Env_lvl(Env_lvl),
    .Env_voice(Env_voice),
    .Env_valid(Env_valid),
    .Env_busy(Env_busy),
    .Env_active(Env_active),
    .Env_ovr(Env_ovr)
  );

  always #5 Sys_clk = ~Sys_clk;

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Scoreboard: every valid output must match the queue head
  always @(negedge Sys_clk) begin
    cyc++;
    if (Env_ovr) ovr_cnt++;
    if (Env_valid) begin
      vcyc.push_back(cyc);
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out voice=%0d lvl=%h required=none",
                 Env_voice, Env_lvl);
      end else begin
        m_e = q.pop_front();
        if (Env_voice !== m_e.v || Env_lvl !== m_e.l) begin
          bad++;
          $display("FAIL stream voice=%0d lvl=%h required voice=%0d lvl=%h",
                   Env_voice, Env_lvl, m_e.v, m_e.l);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push_sweep(input logic [63:0] lv);
    exp_t e;
    for (int v = 0; v < NV; v++) begin
      e.v = 2'(v);
      e.l = lv[16*v +: 16];
      q.push_back(e);
    end
  endtask

  task automatic add(input logic [3:0] k, input logic [15:0] s,
                     input logic [63:0] lv, input logic [3:0] a);
    vec_t t;
    t.key = k;
    t.s   = s;
    t.lv  = lv;
    t.act = a;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge Sys_clk);
    #1 Syn_tick = 1'b1;
    @(posedge Sys_clk);
    #1 Syn_tick = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((q.size() != 0 || Env_busy) && n < 40) begin
      @(posedge Sys_clk);
      n++;
    end
    repeat (2) @(posedge Sys_clk);
    #1;
    chk(nm, 64'(n < 40), 64'd1);
  endtask

  initial begin
    int span;
    A_rate = 32'h4000_0000;
    D_rate = 32'h1000_0000;
    R_rate = 32'h2000_0000;
    S_lvl  = 16'h8000;
    Env_ce = 1'b1;
    repeat (3) @(posedge Sys_clk);
    #1;
    chk("rst_lvl", 64'(Env_lvl), 64'h0);
    chk("rst_voice", 64'(Env_voice), 64'h0);
    chk("rst_valid", 64'(Env_valid), 64'h0);
    chk("rst_busy", 64'(Env_busy), 64'h0);
    chk("rst_active", 64'(Env_active), 64'h0);
    chk("rst_ovr", 64'(Env_ovr), 64'h0);
    Env_rst_n = 1'b1;

    // voice 0: attack, decay to sustain, sustain tracking, release
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_4000, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_8000, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_C000, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_FFFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_EFFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_DFFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_CFFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_BFFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_AFFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_9FFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_8FFF, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_8000, 4'b0001);
    add(4'b0001, 16'h6000, 64'h0000_0000_0000_6000, 4'b0001);
    add(4'b0001, 16'h8000, 64'h0000_0000_0000_8000, 4'b0001);
    add(4'b0000, 16'h8000, 64'h0000_0000_0000_6000, 4'b0001);
    add(4'b0000, 16'h8000, 64'h0000_0000_0000_4000, 4'b0001);
    add(4'b0000, 16'h8000, 64'h0000_0000_0000_2000, 4'b0001);
    add(4'b0000, 16'h8000, 64'h0000_0000_0000_0000, 4'b0000);
    // voice 2: attack, hold in release, retrigger from current level
    add(4'b0100, 16'h8000, 64'h0000_4000_0000_0000, 4'b0100);
    add(4'b0000, 16'h8000, 64'h0000_4000_0000_0000, 4'b0100);
    add(4'b0100, 16'h8000, 64'h0000_8000_0000_0000, 4'b0100);
    add(4'b0000, 16'h8000, 64'h0000_8000_0000_0000, 4'b0100);
    add(4'b0000, 16'h8000, 64'h0000_6000_0000_0000, 4'b0100);
    add(4'b0000, 16'h8000, 64'h0000_4000_0000_0000, 4'b0100);
    add(4'b0000, 16'h8000, 64'h0000_2000_0000_0000, 4'b0100);
    add(4'b0000, 16'h8000, 64'h0000_0000_0000_0000, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge Sys_clk);
      #1;
      Syn_key = vecs[i].key;
      S_lvl   = vecs[i].s;
      push_sweep(vecs[i].lv);
      tick();
      drain($sformatf("drain%0d", i));
      chk($sformatf("active%0d", i), 64'(Env_active), 64'(vecs[i].act));
    end

    // multiplex with a dropped second tick
    @(posedge Sys_clk);
    #1 Syn_key = 4'b1010;
    ovr_cnt = 0;
    vcyc.delete();
    push_sweep(64'h4000_0000_4000_0000);
    tick();
    @(posedge Sys_clk);
    #1 Syn_tick = 1'b1;
    @(posedge Sys_clk);
    #1 Syn_tick = 1'b0;
    drain("drain_mux");
    chk("ovr_count", 64'(ovr_cnt), 64'd1);
    chk("mux_n", 64'(vcyc.size()), 64'd4);
    span = (vcyc.size() == 4) ? vcyc[3] - vcyc[0] : -1;
    chk("mux_span", 64'(span), 64'd3);
    push_sweep(64'h8000_0000_8000_0000);
    tick();
    drain("drain_mux2");
    chk("mux_active", 64'(Env_active), 64'b1010);

    // enable low for 5 cycles after voice 0 is out
    vcyc.delete();
    push_sweep(64'hC000_0000_C000_0000);
    tick();
    @(posedge Sys_clk);
    @(posedge Sys_clk);
    #1 Env_ce = 1'b0;
    repeat (5) @(posedge Sys_clk);
    #1 Env_ce = 1'b1;
    drain("drain_ce");
    chk("ce_n", 64'(vcyc.size()), 64'd4);
    span = (vcyc.size() == 4) ? vcyc[3] - vcyc[0] : -1;
    chk("ce_span", 64'(span), 64'd8);

    // reset while voice 2 is being serviced
    m_e.v = 2'd0;
    m_e.l = 16'h0000;
    q.push_back(m_e);
    tick();
    repeat (3) @(posedge Sys_clk);
    #1 Env_rst_n = 1'b0;
    #1;
    chk("mid_lvl", 64'(Env_lvl), 64'h0);
    chk("mid_valid", 64'(Env_valid), 64'h0);
    chk("mid_busy", 64'(Env_busy), 64'h0);
    chk("mid_active", 64'(Env_active), 64'h0);
    chk("mid_voice", 64'(Env_voice), 64'h0);
    chk("mid_q", 64'(q.size()), 64'h0);
    repeat (2) @(posedge Sys_clk);
    #1 Env_rst_n = 1'b1;
    repeat (10) @(posedge Sys_clk);

    // accumulators restart from zero after reset
    push_sweep(64'h4000_0000_4000_0000);
    tick();
    drain("drain_post");
    chk("post_active", 64'(Env_active), 64'b1010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envelope_bank.md
# envelope_bank

Parametrised, time-multiplexed ADSR envelope generator serving `N_VOICES` independent voices from one shared datapath. It sits between the voice allocator, which supplies per-voice key bits, and the per-voice VCA stage, which consumes the streamed `(Env_voice, Env_lvl)` pairs. Stage rates are taken directly as per-tick increments, so no divider is needed. The block adds true decay-to-sustain, click-free retrigger and release from any stage, and per-voice activity flags.

## Interface
- `N_VOICES`, 8: number of voices; ≥2.
- `LVL_W`, 16: output level width.
- `FRAC_W`, 16: fractional accumulator bits; `ACC_W = LVL_W+FRAC_W`.
- `Sys_clk` in 1: single clock; all logic on rising edge.
- `Env_rst_n` in 1: reset, asynchronous and active-low.
- `Env_ce` in 1: enable; low freezes all state, counters and outputs except `Env_valid`, which is forced low.
- `Syn_tick` in 1: one-cycle update strobe (nominal 1 MHz).
- `Syn_key` in N_VOICES: key-down per voice, level-sensitive.
- `A_rate`, `D_rate`, `R_rate` in ACC_W: unsigned per-tick increment/decrement, shared by all voices.
- `S_lvl` in LVL_W: sustain level.
- `Env_lvl` out LVL_W: level of `Env_voice`, equal to `acc[ACC_W-1:FRAC_W]`.
- `Env_voice` out clog2(N_VOICES): voice index of the current output.
- `Env_valid` out 1: `Env_lvl`/`Env_voice` valid this cycle.
- `Env_busy` out 1: sweep in progress.
- `Env_active` out N_VOICES: per voice, high when state ≠ IDLE.
- `Env_ovr` out 1: one-cycle pulse when a tick is dropped.

## Operation
- Per-voice storage: 3-bit state and an unsigned ACC_W accumulator `acc`. Both reset to IDLE and 0.
- A sweep starts on an accepted tick. Voices 0..N_VOICES-1 are each serviced once, one per cycle, in index order. Key bits are sampled in the voice's service cycle.
- States and per-service transitions (`PEAK` = all-ones ACC_W, `SUS` = `{S_lvl, FRAC_W'b0}`):
  - IDLE: with key high, go to ATTACK and apply the attack step in the same service; `acc` starts from 0. With key low, `acc` holds 0.
  - ATTACK: with key low, go to RELEASE and hold `acc`. Otherwise `acc += A_rate`, computed in ACC_W+1 bits. A result ≥ PEAK clamps to PEAK and moves to DECAY.
  - DECAY: with key low, go to RELEASE. Otherwise `acc -= D_rate`. A result ≤ SUS, or a borrow, clamps to SUS and moves to SUSTAIN.
  - SUSTAIN: `acc = SUS`, re-tracking `S_lvl` every service. With key low, go to RELEASE.
  - RELEASE: with key high, go to ATTACK and add `A_rate` from the current `acc`, with no reset to 0. Otherwise `acc -= R_rate`. A result ≤ 0, or a borrow, gives 0 and IDLE in the same service.
- A rate of 0 holds the level in that stage indefinitely.
- Illegal state encodings go to IDLE with `acc` = 0.
- `S_lvl` changes take effect at the next service.

## Timing
- A tick is accepted when it is sampled high with `Env_ce` high and `Env_busy` low.
- Accepted tick at edge T:
  - `Env_busy` is high from T+1 through T+N_VOICES.
  - Voice v is updated at edge T+1+v.
  - `Env_valid`, `Env_voice`=v and `Env_lvl` (post-update) are registered and visible after edge T+2+v.
- The sweep lasts N_VOICES cycles. Output latency is 1 cycle after the update.
- A tick sampled while `Env_busy` is high is dropped, and `Env_ovr` pulses on the next cycle.
- `Env_active` updates with the voice's state register, so it is visible after edge T+1+v.
- `Env_ce` low mid-sweep: the sweep pauses and resumes at the same voice.
- A tick that coincides with `Env_ce` low is ignored and does not count as overrun.
- Reset values: `Env_lvl`=0, `Env_voice`=0, `Env_valid`=0, `Env_busy`=0, `Env_active`=0, `Env_ovr`=0, all voices IDLE with `acc` = 0.
- Reset asserted mid-sweep aborts the sweep immediately; no partial output is produced.

## Configuration
- `ENV_EXP_RELEASE_EN` defined: the RELEASE decrement is `R_rate + (acc >> 4)`, giving an exponential-like tail. Floor and IDLE rules are unchanged.
- `ENV_EXP_RELEASE_EN` undefined: the RELEASE decrement is `R_rate` (linear). No shifter logic is present.

## Test plan
All scenarios use N_VOICES=4, LVL_W=16, FRAC_W=16.
- Attack: voice 0 key high, `A_rate`=0x4000_0000 → `Env_lvl` 0x4000, 0x8000, 0xC000, 0xFFFF on ticks 1-4; DECAY after tick 4.
- Decay/sustain: `D_rate`=0x1000_0000, `S_lvl`=0x8000 → 0xEFFF, 0xDFFF, …, 0x8000 on the 8th decay tick; SUSTAIN follows. A later `S_lvl`=0x6000 → 0x6000 on the next tick.
- Release (linear, macro off): key low from sustain 0x8000, `R_rate`=0x2000_0000 → 0x6000, 0x4000, 0x2000, 0x0000; `Env_active[0]` falls on the 4th tick.
- Retrigger: key high again at 0x4000 in RELEASE → next output 0x8000 (from `A_rate` 0x4000_0000), not 0x4000-from-zero.
- Multiplex/overrun: keys 4'b1010, second tick 2 cycles after the first → `Env_voice` 0,1,2,3 on consecutive cycles; voices 1 and 3 rise, 0 and 2 stay 0; `Env_ovr` pulses once.
- Reset/enable: `Env_rst_n` low during voice 2 of a sweep → all outputs 0 immediately. `Env_ce` low for 5 cycles mid-sweep → `Env_valid` gaps of 5 cycles, voice order preserved.
